// File: rtl/neural_connect_pkg.sv
// Shared definitions for the neuralConnect lane packer and the parallel-lane buffer chain.
package neural_connect_pkg;

  localparam int MAX_LANES = 64;

  // Counter width for a lane index; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Mask/last side-band carried alongside each parallel beat.
  typedef struct packed {
    logic [MAX_LANES-1:0] mask;
    logic                 last;
  } lane_ctl_t;

endpackage

// File: rtl/lane_packer.sv
// Packs a serial word stream into NUM_LANES-wide beats; a last-flagged word closes a beat early.
module lane_packer
  import neural_connect_pkg::*;
#(
  parameter  int NUM_LANES  = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_WIDTH  = clog2_min1(NUM_LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_last,
  output logic                  data_in_ready,
  output logic                  data_out_valid,
  output logic [DATA_WIDTH-1:0] data_out [NUM_LANES],
  output logic [NUM_LANES-1:0]  data_out_mask,
  output logic                  data_out_last,
  input  logic                  data_out_ready
);

  logic [DATA_WIDTH-1:0] coll_q [NUM_LANES];
  logic [DATA_WIDTH-1:0] coll_d [NUM_LANES];
  logic [NUM_LANES-1:0]  cmask_q, cmask_d;
  logic                  clast_q, clast_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] dout_q [NUM_LANES];
  logic [DATA_WIDTH-1:0] dout_d [NUM_LANES];
  logic [NUM_LANES-1:0]  omask_q, omask_d;
  logic                  olast_q, olast_d;
  logic                  ovalid_q, ovalid_d;

  logic in_fire, out_fire, out_free, complete;

  // Ready depends only on registered state, so there is no path from the output side.
  assign data_in_ready  = ~pending_q;
  assign in_fire        = data_in_valid & ~pending_q;
  assign out_fire       = ovalid_q & data_out_ready;
  assign out_free       = ~ovalid_q | data_out_ready;
  assign complete       = in_fire & ((cnt_q == CNT_WIDTH'(NUM_LANES - 1)) | data_in_last);

  assign data_out_valid = ovalid_q;
  assign data_out       = dout_q;
  assign data_out_mask  = omask_q;
  assign data_out_last  = olast_q;

  always_comb begin
    coll_d    = coll_q;
    cmask_d   = cmask_q;
    clast_d   = clast_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    dout_d    = dout_q;
    omask_d   = omask_q;
    olast_d   = olast_q;
    ovalid_d  = ovalid_q;

    if (out_fire) begin
      ovalid_d = 1'b0;
    end

    if (pending_q) begin
      if (out_free) begin
        dout_d    = coll_q;
        omask_d   = cmask_q;
        olast_d   = clast_q;
        ovalid_d  = 1'b1;
        pending_d = 1'b0;
        cnt_d     = '0;
        coll_d    = '{default: '0};
        cmask_d   = '0;
        clast_d   = 1'b0;
      end
    end else if (in_fire) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (CNT_WIDTH'(i) == cnt_q) begin
          coll_d[i]  = data_in;
          cmask_d[i] = 1'b1;
        end
      end
      if (complete) begin
        if (out_free) begin
          // Bypass the collect register so the closing word leaves on the same edge.
          dout_d   = coll_d;
          omask_d  = cmask_d;
          olast_d  = data_in_last;
          ovalid_d = 1'b1;
          cnt_d    = '0;
          coll_d   = '{default: '0};
          cmask_d  = '0;
          clast_d  = 1'b0;
        end else begin
          clast_d   = data_in_last;
          pending_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q    <= '{default: '0};
      cmask_q   <= '0;
      clast_q   <= 1'b0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      dout_q    <= '{default: '0};
      omask_q   <= '0;
      olast_q   <= 1'b0;
      ovalid_q  <= 1'b0;
    end else begin
      coll_q    <= coll_d;
      cmask_q   <= cmask_d;
      clast_q   <= clast_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      dout_q    <= dout_d;
      omask_q   <= omask_d;
      olast_q   <= olast_d;
      ovalid_q  <= ovalid_d;
    end
  end

endmodule

// File: tb/tb_lane_packer.sv
// Directed bench for lane_packer: 4-lane vector table plus reset, streaming and 1-lane sequences.
module tb_lane_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data [4];
  logic [3:0] out_mask;
  logic [31:0] out_flat;

  logic       v1_valid, v1_last, v1_ready, v1_ovalid, v1_olast, v1_oready;
  logic [7:0] v1_data;
  logic [7:0] v1_odata [1];
  logic [0:0] v1_omask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lane_packer #(.NUM_LANES(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_valid(in_valid), .data_in(in_data), .data_in_last(in_last),
    .data_in_ready(in_ready),
    .data_out_valid(out_valid), .data_out(out_data), .data_out_mask(out_mask),
    .data_out_last(out_last), .data_out_ready(out_ready)
  );

  lane_packer #(.NUM_LANES(1), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .data_in_valid(v1_valid), .data_in(v1_data), .data_in_last(v1_last),
    .data_in_ready(v1_ready),
    .data_out_valid(v1_ovalid), .data_out(v1_odata), .data_out_mask(v1_omask),
    .data_out_last(v1_olast), .data_out_ready(v1_oready)
  );

  always_comb begin
    out_flat = '0;
    for (int i = 0; i < 4; i++) out_flat[i*8 +: 8] = out_data[i];
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_data;
    logic [3:0]  e_mask;
    logic        e_last;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [7:0] d, input logic l, input logic ordy,
                              input logic e_rdy, input logic e_ov, input logic [31:0] e_data,
                              input logic [3:0] e_mask, input logic e_last);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.ordy = ordy;
    x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_data = e_data; x.e_mask = e_mask; x.e_last = e_last;
    vecs.push_back(x);
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic ordy);
    in_valid = v; in_data = d; in_last = l; out_ready = ordy;
  endtask

  initial begin
    int stalls;
    rst_n = 1'b0;
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    v1_valid = 1'b0; v1_data = 8'h00; v1_last = 1'b0; v1_oready = 1'b1;

    // Stream 11..44, then partial A1,A2(last), then B beat landing from lane 0.
    add(1, 8'h11, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    add(1, 8'h22, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    add(1, 8'h33, 0, 1, 1, 0, 32'h0,        4'h0, 0);
    add(1, 8'h44, 0, 1, 1, 1, 32'h44332211, 4'hF, 0);
    add(0, 8'h00, 0, 1, 1, 0, 32'h44332211, 4'hF, 0);
    add(1, 8'hA1, 0, 1, 1, 0, 32'h44332211, 4'hF, 0);
    add(1, 8'hA2, 1, 1, 1, 1, 32'h0000A2A1, 4'h3, 1);
    add(1, 8'hB1, 0, 1, 1, 0, 32'h0000A2A1, 4'h3, 1);
    add(1, 8'hB2, 0, 1, 1, 0, 32'h0000A2A1, 4'h3, 1);
    add(1, 8'hB3, 0, 1, 1, 0, 32'h0000A2A1, 4'h3, 1);
    add(1, 8'hB4, 0, 1, 1, 1, 32'hB4B3B2B1, 4'hF, 0);
    // C beat, then held with out_ready=0 while D arrives and goes pending.
    add(1, 8'hC1, 0, 1, 1, 0, 32'hB4B3B2B1, 4'hF, 0);
    add(1, 8'hC2, 0, 1, 1, 0, 32'hB4B3B2B1, 4'hF, 0);
    add(1, 8'hC3, 0, 1, 1, 0, 32'hB4B3B2B1, 4'hF, 0);
    add(1, 8'hC4, 0, 1, 1, 1, 32'hC4C3C2C1, 4'hF, 0);
    add(1, 8'hD1, 0, 0, 1, 1, 32'hC4C3C2C1, 4'hF, 0);
    add(1, 8'hD2, 0, 0, 1, 1, 32'hC4C3C2C1, 4'hF, 0);
    add(1, 8'hD3, 0, 0, 1, 1, 32'hC4C3C2C1, 4'hF, 0);
    add(1, 8'hD4, 0, 0, 0, 1, 32'hC4C3C2C1, 4'hF, 0);
    add(1, 8'hE1, 0, 1, 1, 1, 32'hD4D3D2D1, 4'hF, 0);
    add(1, 8'hE1, 0, 1, 1, 0, 32'hD4D3D2D1, 4'hF, 0);
    add(1, 8'hE2, 0, 1, 1, 0, 32'hD4D3D2D1, 4'hF, 0);
    add(1, 8'hE3, 0, 1, 1, 0, 32'hD4D3D2D1, 4'hF, 0);
    add(1, 8'hE4, 1, 1, 1, 1, 32'hE4E3E2E1, 4'hF, 1);
    add(0, 8'h00, 0, 1, 1, 0, 32'hE4E3E2E1, 4'hF, 1);

    #1;
    chk("reset_ready", in_ready, 1'b1);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_data", out_flat, 32'h0);
    chk("reset_mask", out_mask, 4'h0);
    chk("reset_last", out_last, 1'b0);
    @(negedge clk);
    chk("reset_hold_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].d, vecs[k].l, vecs[k].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", k), in_ready,  vecs[k].e_rdy);
      chk($sformatf("vec%0d_valid", k), out_valid, vecs[k].e_ov);
      chk($sformatf("vec%0d_data", k),  out_flat,  vecs[k].e_data);
      chk($sformatf("vec%0d_mask", k),  out_mask,  vecs[k].e_mask);
      chk($sformatf("vec%0d_last", k),  out_last,  vecs[k].e_last);
    end

    // 12 back-to-back words: a beat every 4th cycle, never a stall.
    stalls = 0;
    for (int c = 0; c < 14; c++) begin
      logic exp_ov;
      logic [31:0] exp_d;
      if (c < 12) drive(1'b1, 8'(8'h30 + c), 1'b0, 1'b1);
      else        drive(1'b0, 8'h00, 1'b0, 1'b1);
      if (c < 12 && !in_ready) stalls++;
      @(negedge clk);
      exp_ov = (c < 12) && (c % 4 == 3);
      chk($sformatf("stream%0d_valid", c), out_valid, exp_ov);
      if (exp_ov) begin
        for (int j = 0; j < 4; j++) exp_d[j*8 +: 8] = 8'(8'h30 + c - 3 + j);
        chk($sformatf("stream%0d_data", c), out_flat, exp_d);
        chk($sformatf("stream%0d_mask", c), out_mask, 4'hF);
      end
    end
    chk("stream_stalls", stalls, 0);

    // Reset after two words of a beat; partial data must never appear.
    drive(1'b1, 8'hF1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'hF2, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 8'h99, 1'b0, 1'b1);
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_flat, 32'h0);
    chk("midrst_mask", out_mask, 4'h0);
    chk("midrst_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("midrst_hold_data", out_flat, 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 8'(8'h55 + 8'h11 * c), 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("postrst%0d_valid", c), out_valid, c == 3);
    end
    chk("postrst_data", out_flat, 32'h88776655);
    chk("postrst_mask", out_mask, 4'hF);
    chk("postrst_last", out_last, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);

    // Single-lane build: every word is its own beat.
    v1_valid = 1'b1; v1_data = 8'h01; v1_last = 1'b0;
    @(negedge clk);
    chk("l1_b0_valid", v1_ovalid, 1'b1);
    chk("l1_b0_data", v1_odata[0], 8'h01);
    chk("l1_b0_mask", v1_omask, 1'b1);
    chk("l1_b0_last", v1_olast, 1'b0);
    v1_data = 8'h02; v1_last = 1'b1;
    @(negedge clk);
    chk("l1_b1_valid", v1_ovalid, 1'b1);
    chk("l1_b1_data", v1_odata[0], 8'h02);
    chk("l1_b1_mask", v1_omask, 1'b1);
    chk("l1_b1_last", v1_olast, 1'b1);
    v1_valid = 1'b0; v1_last = 1'b0;
    @(negedge clk);
    chk("l1_idle_valid", v1_ovalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
